// File: rtl/song_reader.sv
// rtl/song_reader.sv - plays {note,length} entries from the song RAM as a timed square wave
// One entry at a time: fetch, decode, play for length beats, then a silent gap.
module song_reader #(
  parameter int ADDR_BITS  = 6,
  parameter int NOTE_BITS  = 3,
  parameter int LEN_BITS   = 3,
  parameter int TICK_DIV   = 100000,
  parameter int BEAT_MS    = 125,
  parameter int GAP_MS     = 10,
  parameter int TONE_SCALE = 0
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic [1:0]                    octave_i,
  output logic                          rd_en_o,
  output logic [ADDR_BITS-1:0]          rd_addr_o,
  input  logic [NOTE_BITS+LEN_BITS-1:0] rd_data_i,
  output logic                          buzzer_o,
  output logic                          busy_o,
  output logic [NOTE_BITS-1:0]          cur_note_o,
  output logic [ADDR_BITS-1:0]          cur_addr_o,
  output logic                          done_o
);

  localparam int DATA_BITS = NOTE_BITS + LEN_BITS;
  localparam int HP_BITS   = 21;
  localparam int MS_BITS   = 16;
  localparam int PRE_BITS  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_BITS-1:0]  PRE_LAST  = PRE_BITS'(TICK_DIV - 1);
  localparam logic [MS_BITS-1:0]   GAP_LAST  = MS_BITS'((GAP_MS > 0) ? GAP_MS - 1 : 0);
  localparam logic [ADDR_BITS-1:0] ADDR_LAST = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_DECODE,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   cur_addr_q, cur_addr_d;
  logic [DATA_BITS-1:0]   data_q, data_d;
  logic [NOTE_BITS-1:0]   note_q, note_d;
  logic [HP_BITS-1:0]     hp_q, hp_d;
  logic [MS_BITS-1:0]     ms_target_q, ms_target_d;
  logic [PRE_BITS-1:0]    pre_q, pre_d;
  logic [MS_BITS-1:0]     ms_q, ms_d;
  logic [HP_BITS-1:0]     tone_cnt_q, tone_cnt_d;
  logic                   tone_q, tone_d;

  logic                   ms_tick;
  logic [NOTE_BITS-1:0]   dec_note;
  logic [LEN_BITS-1:0]    dec_len;
  logic [HP_BITS-1:0]     hp_base;
  logic [HP_BITS-1:0]     hp_sel;

  // Half-period in clk cycles for the mid octave; unused codes stay silent.
  function automatic logic [HP_BITS-1:0] base_hp(input logic [NOTE_BITS-1:0] note);
    logic [HP_BITS-1:0] hp;
    case (note)
      NOTE_BITS'(1): hp = 21'd191113;
      NOTE_BITS'(2): hp = 21'd170262;
      NOTE_BITS'(3): hp = 21'd151686;
      NOTE_BITS'(4): hp = 21'd143172;
      NOTE_BITS'(5): hp = 21'd127553;
      NOTE_BITS'(6): hp = 21'd113636;
      NOTE_BITS'(7): hp = 21'd101239;
      default:       hp = '0;
    endcase
    return hp >> TONE_SCALE;
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cur_addr_q  <= '0;
      data_q      <= '0;
      note_q      <= '0;
      hp_q        <= '0;
      ms_target_q <= '0;
      pre_q       <= '0;
      ms_q        <= '0;
      tone_cnt_q  <= '0;
      tone_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_addr_q  <= cur_addr_d;
      data_q      <= data_d;
      note_q      <= note_d;
      hp_q        <= hp_d;
      ms_target_q <= ms_target_d;
      pre_q       <= pre_d;
      ms_q        <= ms_d;
      tone_cnt_q  <= tone_cnt_d;
      tone_q      <= tone_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_addr_d  = cur_addr_q;
    data_d      = data_q;
    note_d      = note_q;
    hp_d        = hp_q;
    ms_target_d = ms_target_q;
    pre_d       = pre_q;
    ms_d        = ms_q;
    tone_cnt_d  = tone_cnt_q;
    tone_d      = tone_q;

    ms_tick  = (pre_q == PRE_LAST);
    dec_note = data_q[DATA_BITS-1:LEN_BITS];
    dec_len  = data_q[LEN_BITS-1:0];
    hp_base  = base_hp(dec_note);
    hp_sel   = hp_base;
    if (octave_i == 2'd0) begin
      hp_sel = hp_base << 1;
    end else if (octave_i == 2'd2) begin
      hp_sel = hp_base >> 1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d    = S_FETCH;
          cur_addr_d = '0;
        end
      end
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        data_d  = rd_data_i;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_len == '0) begin
          state_d = S_DONE;
        end else begin
          note_d      = dec_note;
          hp_d        = hp_sel;
          ms_target_d = MS_BITS'(dec_len) * MS_BITS'(BEAT_MS);
          pre_d       = '0;
          ms_d        = '0;
          tone_cnt_d  = '0;
          tone_d      = 1'b0;
          state_d     = S_PLAY;
        end
      end
      S_PLAY: begin
        pre_d = ms_tick ? '0 : pre_q + 1'b1;
        if (ms_tick) ms_d = ms_q + 1'b1;
        // A zero half-period (rest) never toggles the tone.
        if (hp_q != '0) begin
          if (tone_cnt_q == hp_q - 1'b1) begin
            tone_cnt_d = '0;
            tone_d     = ~tone_q;
          end else begin
            tone_cnt_d = tone_cnt_q + 1'b1;
          end
        end
        if (ms_tick && (ms_q == ms_target_q - 1'b1)) begin
          state_d    = S_GAP;
          pre_d      = '0;
          ms_d       = '0;
          tone_cnt_d = '0;
          tone_d     = 1'b0;
        end
      end
      S_GAP: begin
        pre_d = ms_tick ? '0 : pre_q + 1'b1;
        if (ms_tick) ms_d = ms_q + 1'b1;
        if (ms_tick && (ms_q == GAP_LAST)) begin
          pre_d = '0;
          ms_d  = '0;
          if (cur_addr_q == ADDR_LAST) begin
            state_d = S_DONE;
          end else begin
            cur_addr_d = cur_addr_q + 1'b1;
            state_d    = S_FETCH;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (stop_i) begin
      state_d = S_IDLE;
      tone_d  = 1'b0;
    end
  end

  // Stop masks the strobes combinationally so the aborting cycle is already quiet.
  assign busy_o     = (state_q != S_IDLE);
  assign rd_en_o    = (state_q == S_FETCH) && !stop_i;
  assign rd_addr_o  = cur_addr_q;
  assign cur_addr_o = cur_addr_q;
  assign buzzer_o   = (state_q == S_PLAY) && tone_q && !stop_i;
  assign cur_note_o = (state_q == S_PLAY) ? note_q : '0;
  assign done_o     = (state_q == S_DONE) && !stop_i;

endmodule

// File: tb/tb_song_reader.sv
// tb/tb_song_reader.sv - self-checking bench for song_reader
// Reduced timing parameters; the RAM is a behavioural array with one-cycle read latency.
module tb_song_reader;

  localparam int AB = 6;
  localparam int NB = 3;
  localparam int LB = 3;
  localparam int DW = NB + LB;
  localparam int TD = 10;
  localparam int BM = 2;
  localparam int GM = 1;
  localparam int TS = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [1:0]    octave = 2'd1;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic [DW-1:0] rd_data = '0;
  logic          buzzer, busy, done;
  logic [NB-1:0] cur_note;
  logic [AB-1:0] cur_addr;
  logic [DW-1:0] mem [64];
  int            cyc = 0;

  song_reader #(
    .ADDR_BITS(AB), .NOTE_BITS(NB), .LEN_BITS(LB), .TICK_DIV(TD),
    .BEAT_MS(BM), .GAP_MS(GM), .TONE_SCALE(TS)
  ) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stop_i(stop), .octave_i(octave),
    .rd_en_o(rd_en), .rd_addr_o(rd_addr), .rd_data_i(rd_data), .buzzer_o(buzzer),
    .busy_o(busy), .cur_note_o(cur_note), .cur_addr_o(cur_addr), .done_o(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

  int checks = 0;
  int failures = 0;
  int fetch_cyc[$];
  int fetch_adr[$];
  int done_cyc[$];
  int hi_cnt, rise_cnt, first_rise;
  logic buz_prev;
  int exp_fc[$];
  int exp_fa[$];
  int exp_done, exp_hi, exp_rises;

  typedef struct {
    int note;
    int len;
    int oct;
    int exp_rise;
    int exp_done;
  } vec_t;
  vec_t vecs[10];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic clear_rec();
    fetch_cyc.delete();
    fetch_adr.delete();
    done_cyc.delete();
    hi_cnt = 0;
    rise_cnt = 0;
    first_rise = -1;
    buz_prev = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
    if (rd_en) begin
      fetch_cyc.push_back(cyc);
      fetch_adr.push_back(int'(rd_addr));
    end
    if (done) done_cyc.push_back(cyc);
    if (buzzer) hi_cnt++;
    if (buzzer && !buz_prev) begin
      rise_cnt++;
      if (first_rise < 0) first_rise = cyc;
    end
    buz_prev = buzzer;
  endtask

  function automatic int hp_of(input int note, input int oct);
    int h;
    case (note)
      1: h = 191113;
      2: h = 170262;
      3: h = 151686;
      4: h = 143172;
      5: h = 127553;
      6: h = 113636;
      7: h = 101239;
      default: h = 0;
    endcase
    h = h / (1 << TS);
    if (oct == 0) h = h * 2;
    else if (oct == 2) h = h / 2;
    return h;
  endfunction

  // Timeline model: each played entry costs fetch+wait+decode, then len beats, then the gap.
  task automatic build_model(input int t0, input int oct);
    int t, addr, len, note, d, h, pe;
    exp_fc.delete();
    exp_fa.delete();
    exp_hi = 0;
    exp_rises = 0;
    t = t0 + 1;
    addr = 0;
    for (int k = 0; k < 64; k++) begin
      exp_fc.push_back(t);
      exp_fa.push_back(addr);
      len  = int'(mem[addr]) % (1 << LB);
      note = int'(mem[addr]) / (1 << LB);
      if (len == 0) begin
        exp_done = t + 3;
        break;
      end
      d  = len * BM * TD;
      pe = t + 3;
      h  = hp_of(note, oct);
      if (h > 0) begin
        for (int c = 0; c < d; c++) begin
          if ((c / h) % 2 == 1) exp_hi++;
          if (c > 0 && (c / h) % 2 == 1 && ((c - 1) / h) % 2 == 0) exp_rises++;
        end
      end
      t = pe + d + GM * TD;
      if (addr == 63) begin
        exp_done = t;
        break;
      end
      addr++;
    end
  endtask

  task automatic run_song(input int oct, output int t0);
    int budget;
    clear_rec();
    octave = oct[1:0];
    start = 1'b1;
    t0 = cyc;
    build_model(t0, oct);
    tick();
    start = 1'b0;
    budget = exp_done - t0 + 50;
    for (int i = 0; i < budget && done_cyc.size() == 0; i++) tick();
    for (int i = 0; i < 4; i++) tick();
  endtask

  task automatic compare_model(input string name);
    int bad;
    bad = 0;
    chk({name, "_fetch_count"}, fetch_cyc.size(), exp_fc.size());
    if (fetch_cyc.size() == exp_fc.size()) begin
      foreach (exp_fc[i])
        if (fetch_cyc[i] != exp_fc[i] || fetch_adr[i] != exp_fa[i]) bad++;
    end
    chk({name, "_fetch_seq_errors"}, bad, 0);
    chk({name, "_done_count"}, done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk({name, "_done_cycle"}, done_cyc[0], exp_done);
    chk({name, "_buzzer_high_cycles"}, hi_cnt, exp_hi);
    chk({name, "_buzzer_rises"}, rise_cnt, exp_rises);
    chk({name, "_busy_after"}, busy, 0);
  endtask

  initial begin
    int t0, n;
    vecs[0] = '{note: 1, len: 1, oct: 1, exp_rise: 0,   exp_done: 37};
    vecs[1] = '{note: 6, len: 7, oct: 0, exp_rise: 0,   exp_done: 157};
    vecs[2] = '{note: 6, len: 3, oct: 2, exp_rise: 59,  exp_done: 77};
    vecs[3] = '{note: 7, len: 3, oct: 2, exp_rise: 53,  exp_done: 77};
    vecs[4] = '{note: 5, len: 4, oct: 2, exp_rise: 66,  exp_done: 97};
    vecs[5] = '{note: 1, len: 7, oct: 3, exp_rise: 0,   exp_done: 157};
    vecs[6] = '{note: 1, len: 5, oct: 2, exp_rise: 97,  exp_done: 117};
    vecs[7] = '{note: 0, len: 2, oct: 1, exp_rise: 0,   exp_done: 57};
    vecs[8] = '{note: 4, len: 7, oct: 1, exp_rise: 143, exp_done: 157};
    vecs[9] = '{note: 3, len: 0, oct: 1, exp_rise: 0,   exp_done: 4};
    foreach (mem[i]) mem[i] = '0;

    clear_rec();
    for (int i = 0; i < 3; i++) tick();
    chk("reset_busy", busy, 0);
    chk("reset_rd_en", rd_en, 0);
    chk("reset_buzzer", buzzer, 0);
    chk("reset_done", done, 0);
    chk("reset_rd_addr", rd_addr, 0);
    chk("reset_cur_addr", cur_addr, 0);
    chk("reset_cur_note", cur_note, 0);
    rst = 1'b0;
    tick();
    tick();

    foreach (vecs[i]) begin
      mem[0] = DW'((vecs[i].note << LB) | vecs[i].len);
      mem[1] = '0;
      run_song(vecs[i].oct, t0);
      chk($sformatf("vec%0d_first_rise", i),
          (first_rise < 0) ? 0 : first_rise - t0, vecs[i].exp_rise);
      chk($sformatf("vec%0d_done_offset", i),
          (done_cyc.size() > 0) ? done_cyc[0] - t0 : -1, vecs[i].exp_done);
      compare_model($sformatf("vec%0d", i));
    end

    // Two-entry song: second fetch lands after play and gap of the first.
    mem[0] = DW'((1 << LB) | 1);
    mem[1] = '0;
    run_song(1, t0);
    chk("t2_fetch1_offset", (fetch_cyc.size() > 1) ? fetch_cyc[1] - t0 : -1, 34);
    chk("t2_fetch1_addr", (fetch_adr.size() > 1) ? fetch_adr[1] : -1, 1);

    // Octave change mid-note keeps the latched half-period.
    mem[0] = DW'((6 << LB) | 7);
    clear_rec();
    octave = 2'd2;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    octave = 2'd0;
    for (int i = 0; i < 160 && done_cyc.size() == 0; i++) tick();
    chk("t4_first_rise", (first_rise < 0) ? 0 : first_rise - t0, 59);
    chk("t4_high_cycles", hi_cnt, 55);
    chk("t4_done_count", done_cyc.size(), 1);
    octave = 2'd1;
    tick();

    // Asynchronous reset in the middle of a high buzzer phase.
    clear_rec();
    octave = 2'd2;
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
    while (cyc < t0 + 70) tick();
    chk("t1_buzzer_before_rst", buzzer, 1);
    chk("t1_cur_note_before_rst", cur_note, 6);
    #2 rst = 1'b1;
    #1;
    chk("t1_rst_buzzer", buzzer, 0);
    chk("t1_rst_busy", busy, 0);
    chk("t1_rst_rd_en", rd_en, 0);
    chk("t1_rst_cur_note", cur_note, 0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t1_idle_after_release", busy, 0);
    chk("t1_no_done", done_cyc.size(), 0);

    // Stop has priority over a simultaneous start.
    clear_rec();
    octave = 2'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("t6_busy_before_stop", busy, 1);
    stop = 1'b1;
    start = 1'b1;
    #1;
    chk("t6_stop_buzzer_mask", buzzer, 0);
    tick();
    chk("t6_busy_after_stop", busy, 0);
    chk("t6_buzzer_after_stop", buzzer, 0);
    stop = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("t6_no_done", done_cyc.size(), 0);
    chk("t6_still_idle", busy, 0);
    mem[0] = DW'((2 << LB) | 1);
    mem[1] = '0;
    run_song(1, t0);
    compare_model("t6_restart");

    // Randomized short songs checked against the timeline model.
    for (int r = 0; r < 6; r++) begin
      n = $urandom_range(1, 10);
      for (int a = 0; a < n; a++)
        mem[a] = DW'(($urandom_range(0, 7) << LB) | $urandom_range(1, 7));
      mem[n] = '0;
      run_song($urandom_range(0, 3), t0);
      compare_model($sformatf("rand%0d", r));
    end

    // Full RAM with no end marker: stops after the last address without wrapping.
    for (int a = 0; a < 64; a++)
      mem[a] = DW'(($urandom_range(0, 7) << LB) | $urandom_range(1, 3));
    run_song($urandom_range(0, 3), t0);
    compare_model("t5_full");
    chk("t5_rd_addr_end", rd_addr, 63);
    chk("t5_last_fetch_addr", (fetch_adr.size() > 0) ? fetch_adr[fetch_adr.size()-1] : -1, 63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
